// File: rtl/idex_stage_s.sv
// idex_stage_s: ID/EX pipeline register with hazard-driven enables, bubbles, operand forwarding and a stall watchdog.
// Optional HAZ_PERF_EN adds free-running stall/flush event counters.
module idex_stage_s #(
  parameter int          DATA_W        = 32,
  parameter bit          FORWARDING_ON = 1'b1,
  parameter int unsigned MAX_STALL     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic              id_regWrite,
  input  logic              id_aluSrc,
  input  logic [3:0]        id_aluOp,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        forwA,
  input  logic [1:0]        forwB,
  input  logic [DATA_W-1:0] exmem_alu_result,
  input  logic [DATA_W-1:0] memwb_wb_data,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic [DATA_W-1:0] idex_pc,
  output logic [DATA_W-1:0] idex_imm,
  output logic [4:0]        idex_rs1,
  output logic [4:0]        idex_rs2,
  output logic [4:0]        idex_rd,
  output logic              idex_memRead,
  output logic              idex_memWrite,
  output logic              idex_regWrite,
  output logic              idex_aluSrc,
  output logic [3:0]        idex_aluOp,
  output logic              idex_valid,
  output logic [DATA_W-1:0] ex_opA,
  output logic [DATA_W-1:0] ex_opB_reg,
  output logic [DATA_W-1:0] ex_opB,
`ifdef HAZ_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic              stall_err
);
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              mr;
    logic              mw;
    logic              rw;
    logic              as;
    logic [3:0]        op;
    logic              v;
  } idex_t;
  idex_t idex_d, idex_q;
  logic [3:0] cnt_d, cnt_q;
  logic err_d, err_q;
  logic [1:0] fa, fb;
  always_comb begin
    idex_d = (flush || stall) ? '0 : idex_t'{id_pc, id_imm, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd,
                                             id_memRead, id_memWrite, id_regWrite, id_aluSrc, id_aluOp, id_valid};
    cnt_d = stall ? cnt_q + {3'b0, cnt_q != 4'hf} : 4'h0;
    err_d = err_q | (stall && 32'(cnt_q) >= MAX_STALL);
    pc_en = ~stall;
    ifid_en = ~stall;
    ifid_flush = flush;
    fa = FORWARDING_ON ? forwA : 2'b00;
    fb = FORWARDING_ON ? forwB : 2'b00;
    ex_opA = fa == 2'b01 ? exmem_alu_result : fa == 2'b10 ? memwb_wb_data : idex_q.d1;
    ex_opB_reg = fb == 2'b01 ? exmem_alu_result : fb == 2'b10 ? memwb_wb_data : idex_q.d2;
    ex_opB = idex_q.as ? idex_q.imm : ex_opB_reg;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      idex_q <= idex_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign idex_pc = idex_q.pc;
  assign idex_imm = idex_q.imm;
  assign idex_rs1 = idex_q.rs1;
  assign idex_rs2 = idex_q.rs2;
  assign idex_rd = idex_q.rd;
  assign idex_memRead = idex_q.mr;
  assign idex_memWrite = idex_q.mw;
  assign idex_regWrite = idex_q.rw;
  assign idex_aluSrc = idex_q.as;
  assign idex_aluOp = idex_q.op;
  assign idex_valid = idex_q.v;
  assign stall_err = err_q;
`ifdef HAZ_PERF_EN
  logic [31:0] ps_d, ps_q, pf_d, pf_q;
  always_comb begin
    ps_d = ps_q + {31'b0, stall};
    pf_d = pf_q + {31'b0, flush};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= '0;
      pf_q <= '0;
    end else begin
      ps_q <= ps_d;
      pf_q <= pf_d;
    end
  end
  assign perf_stall_cnt = ps_q;
  assign perf_flush_cnt = pf_q;
`endif
endmodule
